// File: rtl/wb_ram_pkg.sv
// rtl/wb_ram_pkg.sv - shared widths and round-robin pick for the multi-port banked RAM
// Ports: none (package). Imported by wb_ram_bank and wb_ram_mp.
package wb_ram_pkg;

   // Largest supported port count; the round-robin pick works on vectors this wide.
   localparam int MAX_PORTS  = 8;
   localparam int PORT_IDX_W = 3;

   // Default geometry and the widths derived from it.
   localparam int DEF_NUM_BANKS  = 2;
   localparam int DEF_BANK_DEPTH = 256;

   // A single bank needs no select bits; the address is then all offset.
   function automatic int bankSelW(input int numBanks);
      return (numBanks > 1) ? $clog2(numBanks) : 0;
   endfunction

   localparam int BANK_SEL_W = bankSelW(DEF_NUM_BANKS);
   localparam int OFFS_W     = $clog2(DEF_BANK_DEPTH);

   // One-hot grant of the first requester found searching upward from last+1,
   // wrapping at numPorts. All-zero when nobody requests.
   function automatic logic [MAX_PORTS-1:0] rr_pick(
      input logic [MAX_PORTS-1:0]  reqVec,
      input logic [PORT_IDX_W-1:0] last,
      input int                    numPorts
   );
      logic [MAX_PORTS-1:0]  grant;
      logic                  found;
      logic [PORT_IDX_W-1:0] idx;
      grant = '0;
      found = 1'b0;
      for (int i = 1; i <= MAX_PORTS; i++) begin
         if (i <= numPorts) begin
            idx = PORT_IDX_W'((int'(last) + i) % numPorts);
            if (!found && reqVec[idx]) begin
               grant[idx] = 1'b1;
               found      = 1'b1;
            end
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/DFFRAM256x32.sv
// rtl/DFFRAM256x32.sv - simulation model of the 256x32 DFFRAM macro
// Ports: CLK clock; EN0 enable; WE0[3:0] byte write enables (all zero = read);
//        A0[7:0] word address; Di0[31:0] write data; Do0[31:0] registered read data.
module DFFRAM256x32 (
   input  logic        CLK,
   input  logic [3:0]  WE0,
   input  logic        EN0,
   input  logic [7:0]  A0,
   input  logic [31:0] Di0,
   output logic [31:0] Do0
);

   logic [31:0] mem [256];

   always_ff @(posedge CLK) begin
      if (EN0) begin
         for (int i = 0; i < 4; i++) begin
            if (WE0[i]) begin
               mem[A0][i*8 +: 8] <= Di0[i*8 +: 8];
            end
         end
         if (WE0 == 4'b0000) begin
            Do0 <= mem[A0];
         end
      end
   end

endmodule

// File: rtl/wb_ram_bank.sv
// rtl/wb_ram_bank.sv - single-port byte-writable RAM bank, one-cycle read latency
// Ports: clk clock; en access enable; we write (else read); sel byte enables;
//        addr word address; wrData write data; rdData read data (valid cycle after a read).
module wb_ram_bank
   import wb_ram_pkg::*;
#(
   parameter  int DEPTH  = 256,
   parameter  int DATA_W = 32,
   localparam int SEL_W  = DATA_W / 8,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [SEL_W-1:0]  sel,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wrData,
   output logic [DATA_W-1:0] rdData
);

   generate
      if (DEPTH == 256 && DATA_W == 32) begin : g_macro
         DFFRAM256x32 u_ram (
            .CLK (clk),
            .WE0 ({SEL_W{we}} & sel),
            .EN0 (en),
            .A0  (addr),
            .Di0 (wrData),
            .Do0 (rdData)
         );
      end else begin : g_behav
         logic [DATA_W-1:0] mem [DEPTH];

         // Write cycles leave rdData alone; the port returns zero on write acks anyway.
         always_ff @(posedge clk) begin
            if (en) begin
               if (we) begin
                  for (int i = 0; i < SEL_W; i++) begin
                     if (sel[i]) begin
                        mem[addr][i*8 +: 8] <= wrData[i*8 +: 8];
                     end
                  end
               end else begin
                  rdData <= mem[addr];
               end
            end
         end
      end
   endgenerate

endmodule

// File: rtl/wb_ram_mp.sv
// rtl/wb_ram_mp.sv - multi-port pipelined Wishbone SRAM with per-bank round-robin arbitration
// Ports: wb_clk clock; wb_reset_n sync active-low reset;
//        wb_cyc_i/wb_stb_i/wb_we_i per-port cycle, strobe, write;
//        wb_sel_i/wb_adr_i/wb_dat_i per-port byte selects, word address, write data (packed);
//        wb_dat_o/wb_ack_o/wb_stall_o per-port read data, acknowledge, stall.
module wb_ram_mp
   import wb_ram_pkg::*;
#(
   parameter  int NUM_PORTS  = 2,
   parameter  int NUM_BANKS  = 2,
   parameter  int BANK_DEPTH = 256,
   parameter  int DATA_W     = 32,
   localparam int SEL_W      = DATA_W / 8,
   localparam int ADDR_W     = $clog2(NUM_BANKS * BANK_DEPTH)
) (
   input  logic                          wb_clk,
   input  logic                          wb_reset_n,
   input  logic [NUM_PORTS-1:0]          wb_cyc_i,
   input  logic [NUM_PORTS-1:0]          wb_stb_i,
   input  logic [NUM_PORTS-1:0]          wb_we_i,
   input  logic [NUM_PORTS*SEL_W-1:0]    wb_sel_i,
   input  logic [NUM_PORTS*ADDR_W-1:0]   wb_adr_i,
   input  logic [NUM_PORTS*DATA_W-1:0]   wb_dat_i,
   output logic [NUM_PORTS*DATA_W-1:0]   wb_dat_o,
   output logic [NUM_PORTS-1:0]          wb_ack_o,
   output logic [NUM_PORTS-1:0]          wb_stall_o
);

   localparam int BSEL_W = bankSelW(NUM_BANKS);
   localparam int BSW    = (BSEL_W > 0) ? BSEL_W : 1;
   localparam int OFF_W  = $clog2(BANK_DEPTH);

   logic [NUM_PORTS-1:0]  req;
   logic [NUM_PORTS-1:0]  granted;
   logic [BSW-1:0]        portBank [NUM_PORTS];
   logic [OFF_W-1:0]      portOff  [NUM_PORTS];

   logic [NUM_PORTS-1:0]  bankGrant  [NUM_BANKS];
   logic [PORT_IDX_W-1:0] bankWinner [NUM_BANKS];
   logic                  bankEn     [NUM_BANKS];
   logic                  bankWe     [NUM_BANKS];
   logic [SEL_W-1:0]      bankSel    [NUM_BANKS];
   logic [OFF_W-1:0]      bankAddr   [NUM_BANKS];
   logic [DATA_W-1:0]     bankWrData [NUM_BANKS];
   logic [DATA_W-1:0]     bankRdData [NUM_BANKS];

   logic [PORT_IDX_W-1:0] lastGrant [NUM_BANKS];
   logic [NUM_PORTS-1:0]  ackPend;
   logic [NUM_PORTS-1:0]  ackIsRead;
   logic [BSW-1:0]        ackBank [NUM_PORTS];

   assign req = wb_cyc_i & wb_stb_i;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
      assign portOff[p] = wb_adr_i[p*ADDR_W +: OFF_W];
      if (BSEL_W > 0) begin : g_sel
         assign portBank[p] = wb_adr_i[p*ADDR_W + OFF_W +: BSEL_W];
      end else begin : g_one
         assign portBank[p] = '0;
      end
   end

   // Per-bank arbitration and request steering. Nothing is granted while
   // reset is asserted, so stall simply follows req then.
   always_comb begin
      logic [MAX_PORTS-1:0] reqVec;
      logic [MAX_PORTS-1:0] pick;
      granted = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         reqVec = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            reqVec[p] = req[p] && wb_reset_n && (portBank[p] == BSW'(b));
         end
         pick          = rr_pick(reqVec, lastGrant[b], NUM_PORTS);
         bankGrant[b]  = pick[NUM_PORTS-1:0];
         bankWinner[b] = '0;
         for (int p = 0; p < MAX_PORTS; p++) begin
            if (pick[p]) bankWinner[b] = PORT_IDX_W'(p);
         end
         bankEn[b]     = |bankGrant[b];
         bankWe[b]     = 1'b0;
         bankSel[b]    = '0;
         bankAddr[b]   = '0;
         bankWrData[b] = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (bankGrant[b][p]) begin
               bankWe[b]     = wb_we_i[p];
               bankSel[b]    = wb_sel_i[p*SEL_W +: SEL_W];
               bankAddr[b]   = portOff[p];
               bankWrData[b] = wb_dat_i[p*DATA_W +: DATA_W];
            end
         end
         granted = granted | bankGrant[b];
      end
   end

   assign wb_stall_o = req & ~granted;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      wb_ram_bank #(
         .DEPTH  (BANK_DEPTH),
         .DATA_W (DATA_W)
      ) u_bank (
         .clk    (wb_clk),
         .en     (bankEn[b]),
         .we     (bankWe[b]),
         .sel    (bankSel[b]),
         .addr   (bankAddr[b]),
         .wrData (bankWrData[b]),
         .rdData (bankRdData[b])
      );
   end

   always_ff @(posedge wb_clk) begin
      if (!wb_reset_n) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            lastGrant[b] <= PORT_IDX_W'(NUM_PORTS - 1);
         end
         ackPend   <= '0;
         ackIsRead <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            ackBank[p] <= '0;
         end
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (bankEn[b]) lastGrant[b] <= bankWinner[b];
         end
         ackPend   <= granted;
         ackIsRead <= granted & ~wb_we_i;
         for (int p = 0; p < NUM_PORTS; p++) begin
            ackBank[p] <= portBank[p];
         end
      end
   end

   // A dropped cycle swallows its ack; reset hides any ack still in flight.
   assign wb_ack_o = ackPend & wb_cyc_i & {NUM_PORTS{wb_reset_n}};

   always_comb begin
      wb_dat_o = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (wb_ack_o[p] && ackIsRead[p]) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
               if (ackBank[p] == BSW'(b)) wb_dat_o[p*DATA_W +: DATA_W] = bankRdData[b];
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_ram_mp.sv
// tb/tb_wb_ram_mp.sv - directed self-checking bench for wb_ram_mp (2 ports, 2 banks)
module tb_wb_ram_mp;

   logic        clk;
   logic        resetN;
   logic [1:0]  cyc, stb, we;
   logic [7:0]  sel;
   logic [17:0] adr;
   logic [63:0] datI;
   logic [63:0] datO;
   logic [1:0]  ack, stall;

   int checks;
   int errors;

   wb_ram_mp dut (
      .wb_clk     (clk),
      .wb_reset_n (resetN),
      .wb_cyc_i   (cyc),
      .wb_stb_i   (stb),
      .wb_we_i    (we),
      .wb_sel_i   (sel),
      .wb_adr_i   (adr),
      .wb_dat_i   (datI),
      .wb_dat_o   (datO),
      .wb_ack_o   (ack),
      .wb_stall_o (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic c, input logic s, input logic w,
                        input logic [3:0] sl, input logic [8:0] a, input logic [31:0] d);
      cyc[p]            = c;
      stb[p]            = s;
      we[p]             = w;
      sel[p*4 +: 4]     = sl;
      adr[p*9 +: 9]     = a;
      datI[p*32 +: 32]  = d;
   endtask

   task automatic idle;
      drive(0, 1'b0, 1'b0, 1'b0, 4'h0, 9'h000, 32'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 9'h000, 32'h0);
   endtask

   task automatic test_reset;
      resetN = 1'b0;
      idle();
      tick();
      tick();
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 9'h005, 32'h0);
      @(negedge clk);
      checks++; if (stall !== 2'b01) begin errors++; $display("FAIL reset_stall: got %b expected %b", stall, 2'b01); end
      checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected %b", ack, 2'b00); end
      checks++; if (datO !== 64'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", datO); end
      tick();
      resetN = 1'b1;
      drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h005, 32'h0);
      @(negedge clk);
      checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_no_grant: got %b expected %b", ack, 2'b00); end
      tick();
      idle();
   endtask

   task automatic test_single;
      drive(0, 1'b1, 1'b1, 1'b1, 4'hF, 9'h005, 32'hDEADBEEF);
      @(negedge clk);
      checks++; if (stall !== 2'b00) begin errors++; $display("FAIL single_wr_stall: got %b expected 00", stall); end
      tick();
      drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h005, 32'h0);
      @(negedge clk);
      checks++; if (ack !== 2'b01) begin errors++; $display("FAIL single_wr_ack: got %b expected 01", ack); end
      checks++; if (datO[31:0] !== 32'h0) begin errors++; $display("FAIL single_wr_dat: got %h expected 0", datO[31:0]); end
      tick();
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 9'h005, 32'h0);
      @(negedge clk);
      checks++; if (stall !== 2'b00) begin errors++; $display("FAIL single_rd_stall: got %b expected 00", stall); end
      checks++; if (ack !== 2'b00) begin errors++; $display("FAIL single_idle_ack: got %b expected 00", ack); end
      tick();
      drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h005, 32'h0);
      @(negedge clk);
      checks++; if (ack !== 2'b01) begin errors++; $display("FAIL single_rd_ack: got %b expected 01", ack); end
      checks++; if (datO[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rd_dat: got %h expected deadbeef", datO[31:0]); end
      tick();
      idle();
   endtask

   task automatic test_byte_write;
      drive(0, 1'b1, 1'b1, 1'b1, 4'hF, 9'h010, 32'h11223344);
      tick();
      drive(0, 1'b1, 1'b1, 1'b1, 4'h2, 9'h010, 32'hAABBCCDD);
      tick();
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 9'h010, 32'h0);
      tick();
      drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h010, 32'h0);
      @(negedge clk);
      checks++; if (ack !== 2'b01) begin errors++; $display("FAIL byte_ack: got %b expected 01", ack); end
      checks++; if (datO[31:0] !== 32'h1122CC44) begin errors++; $display("FAIL byte_dat: got %h expected 1122cc44", datO[31:0]); end
      tick();
      idle();
   endtask

   task automatic test_contention;
      int cnt0, cnt1;
      logic [1:0] expStall, expAck;
      drive(0, 1'b1, 1'b1, 1'b1, 4'hF, 9'h020, 32'hA0A0A0A0);
      tick();
      drive(0, 1'b1, 1'b1, 1'b1, 4'hF, 9'h021, 32'hA1A1A1A1);
      tick();
      idle();
      resetN = 1'b0;
      tick();
      resetN = 1'b1;
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 9'h020, 32'h0);
      drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 9'h021, 32'h0);
      cnt0 = 0;
      cnt1 = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         expStall = (i % 2 == 0) ? 2'b10 : 2'b01;
         checks++; if (stall !== expStall) begin errors++; $display("FAIL rr_stall[%0d]: got %b expected %b", i, stall, expStall); end
         if (i > 0) begin
            expAck = (i % 2 == 1) ? 2'b01 : 2'b10;
            checks++; if (ack !== expAck) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", i, ack, expAck); end
            if (i % 2 == 1) begin
               checks++; if (datO[31:0] !== 32'hA0A0A0A0) begin errors++; $display("FAIL rr_dat0[%0d]: got %h expected a0a0a0a0", i, datO[31:0]); end
            end else begin
               checks++; if (datO[63:32] !== 32'hA1A1A1A1) begin errors++; $display("FAIL rr_dat1[%0d]: got %h expected a1a1a1a1", i, datO[63:32]); end
            end
         end
         cnt0 += int'(ack[0]);
         cnt1 += int'(ack[1]);
         tick();
      end
      drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h020, 32'h0);
      drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 9'h021, 32'h0);
      @(negedge clk);
      checks++; if (ack !== 2'b10) begin errors++; $display("FAIL rr_last_ack: got %b expected 10", ack); end
      checks++; if (datO[63:32] !== 32'hA1A1A1A1) begin errors++; $display("FAIL rr_last_dat: got %h expected a1a1a1a1", datO[63:32]); end
      cnt0 += int'(ack[0]);
      cnt1 += int'(ack[1]);
      checks++; if (cnt0 !== 2) begin errors++; $display("FAIL rr_count0: got %0d expected 2", cnt0); end
      checks++; if (cnt1 !== 2) begin errors++; $display("FAIL rr_count1: got %0d expected 2", cnt1); end
      tick();
      idle();
   endtask

   task automatic test_parallel;
      drive(0, 1'b1, 1'b1, 1'b1, 4'hF, 9'h003, 32'h33333333);
      drive(1, 1'b1, 1'b1, 1'b1, 4'hF, 9'h103, 32'h13131313);
      @(negedge clk);
      checks++; if (stall !== 2'b00) begin errors++; $display("FAIL par_wr_stall: got %b expected 00", stall); end
      tick();
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 9'h003, 32'h0);
      drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 9'h103, 32'h0);
      @(negedge clk);
      checks++; if (stall !== 2'b00) begin errors++; $display("FAIL par_rd_stall: got %b expected 00", stall); end
      checks++; if (ack !== 2'b11) begin errors++; $display("FAIL par_wr_ack: got %b expected 11", ack); end
      tick();
      stb = 2'b00;
      @(negedge clk);
      checks++; if (ack !== 2'b11) begin errors++; $display("FAIL par_rd_ack: got %b expected 11", ack); end
      checks++; if (datO !== 64'h13131313_33333333) begin errors++; $display("FAIL par_rd_dat: got %h expected 1313131333333333", datO); end
      tick();
      idle();
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, 1'b1, 1'b1, 4'hF, 9'(i), 32'(i + 1));
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 9'(i), 32'h0);
         @(negedge clk);
         checks++; if (stall !== 2'b00) begin errors++; $display("FAIL b2b_stall[%0d]: got %b expected 00", i, stall); end
         checks++; if (ack !== 2'b01) begin errors++; $display("FAIL b2b_ack[%0d]: got %b expected 01", i, ack); end
         checks++; if (datO[31:0] !== 32'(i)) begin errors++; $display("FAIL b2b_dat[%0d]: got %h expected %h", i, datO[31:0], 32'(i)); end
         tick();
      end
      drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h000, 32'h0);
      @(negedge clk);
      checks++; if (ack !== 2'b01) begin errors++; $display("FAIL b2b_last_ack: got %b expected 01", ack); end
      checks++; if (datO[31:0] !== 32'd4) begin errors++; $display("FAIL b2b_last_dat: got %h expected 4", datO[31:0]); end
      tick();
      @(negedge clk);
      checks++; if (ack !== 2'b00) begin errors++; $display("FAIL b2b_extra_ack: got %b expected 00", ack); end
      idle();
      tick();
   endtask

   task automatic test_abort;
      drive(1, 1'b1, 1'b1, 1'b1, 4'hF, 9'h050, 32'h55AA55AA);
      tick();
      drive(1, 1'b0, 1'b0, 1'b0, 4'hF, 9'h050, 32'h0);
      @(negedge clk);
      checks++; if (ack !== 2'b00) begin errors++; $display("FAIL abort_ack: got %b expected 00", ack); end
      tick();
      drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 9'h050, 32'h0);
      tick();
      drive(1, 1'b1, 1'b0, 1'b0, 4'hF, 9'h050, 32'h0);
      @(negedge clk);
      checks++; if (ack !== 2'b10) begin errors++; $display("FAIL abort_rd_ack: got %b expected 10", ack); end
      checks++; if (datO[63:32] !== 32'h55AA55AA) begin errors++; $display("FAIL abort_rd_dat: got %h expected 55aa55aa", datO[63:32]); end
      tick();
      idle();
   endtask

   task automatic test_reset_mid;
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 9'h010, 32'h0);
      tick();
      drive(0, 1'b1, 1'b0, 1'b0, 4'hF, 9'h010, 32'h0);
      resetN = 1'b0;
      @(negedge clk);
      checks++; if (ack !== 2'b00) begin errors++; $display("FAIL rst_mid_ack: got %b expected 00", ack); end
      tick();
      resetN = 1'b1;
      @(negedge clk);
      checks++; if (ack !== 2'b00) begin errors++; $display("FAIL rst_mid_dropped: got %b expected 00", ack); end
      tick();
      drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 9'h010, 32'h0);
      drive(1, 1'b1, 1'b1, 1'b0, 4'hF, 9'h020, 32'h0);
      @(negedge clk);
      checks++; if (stall !== 2'b10) begin errors++; $display("FAIL rst_mid_prio: got %b expected 10", stall); end
      tick();
      stb = 2'b00;
      @(negedge clk);
      checks++; if (ack !== 2'b01) begin errors++; $display("FAIL rst_mid_ack2: got %b expected 01", ack); end
      checks++; if (datO[31:0] !== 32'h1122CC44) begin errors++; $display("FAIL rst_mid_mem: got %h expected 1122cc44", datO[31:0]); end
      tick();
      idle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      resetN = 1'b0;
      cyc    = '0;
      stb    = '0;
      we     = '0;
      sel    = '0;
      adr    = '0;
      datI   = '0;
      test_reset();
      test_single();
      test_byte_write();
      test_contention();
      test_parallel();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
